// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC3 memory front end: FSM states, wait-state counter
// width and the native 16-bit request record.
package lc3_mem_pkg;

  localparam int WS_W  = 4;
  localparam int LC3_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic             we;
    logic [LC3_W-1:0] addr;
    logic [LC3_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/lc3_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after rr_ptr,
// wrapping, returned both as a one-hot grant and as an index.
module lc3_rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  idx
);

  always_comb begin
    int   c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(rr_ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req[PTR_W'(c)]) begin
        found               = 1'b1;
        grant[PTR_W'(c)]    = 1'b1;
        idx                 = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/lc3_mem_arb.sv
// N-channel LC3 memory front end: round-robin arbitration, programmable wait
// states, address range check and a one-cycle ack back to the granted channel.
module lc3_mem_arb
  import lc3_mem_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int MEM_DEPTH   = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ack,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        addr,
  output logic                     memWE,
  output logic [DATA_W-1:0]        data_in,
  input  logic [DATA_W-1:0]        data_out
);

  localparam int              PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [WS_W-1:0] WS_INIT = WS_W'(WAIT_STATES);

  state_t              state_q, state_d;
  logic [WS_W-1:0]     cnt_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [PTR_W-1:0]    grant_idx_q;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;

  logic [NUM_CH-1:0]   arb_grant;
  logic [PTR_W-1:0]    arb_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                in_range;

  lc3_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .idx    (arb_idx)
  );

  // Steer the granted channel's request fields using the one-hot grant.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) begin
        sel_we    = we[i];
        sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_range = ({1'b0, lat_addr} < DEPTH_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // memWE and ack decode straight from state so a reset drops them at once.
  always_comb begin
    state_d = state_q;
    memWE   = 1'b0;
    ack     = '0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          memWE   = lat_we & in_range;
        end
      end
      RESP: begin
        state_d          = IDLE;
        ack[grant_idx_q] = 1'b1;
        err              = !in_range;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata_q     <= '0;
    end else begin
      if (state_q == IDLE && |req) begin
        lat_we      <= sel_we;
        lat_addr    <= sel_addr;
        lat_wdata   <= sel_wdata;
        cnt_q       <= WS_INIT;
        grant_idx_q <= arb_idx;
        rr_ptr_q    <= (arb_idx == PTR_W'(NUM_CH-1)) ? '0 : arb_idx + 1'b1;
      end
      if (state_q == ACCESS) begin
        if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
        else             rdata_q <= in_range ? data_out : '0;
      end
    end
  end

  assign addr    = lat_addr;
  assign data_in = lat_wdata;
  assign rdata   = rdata_q;

  // A requester must hold req until its ack; dropping it early is a protocol error.
  req_held_during_access: assert property (
    @(posedge clk) disable iff (rst) (state_q == ACCESS) |-> req[grant_idx_q]
  );

endmodule

// File: tb/tb_lc3_mem_arb.sv
// Directed bench for lc3_mem_arb: vector table for single transactions plus
// hand sequences for round-robin, reset abort and wait-state latency.
module tb_lc3_mem_arb;

  typedef struct {
    int          ch;
    logic        wr;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] mem;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we_cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] ch_addr, ch_wdata;
  logic [1:0]  ack;
  logic        err;
  logic [15:0] rdata, addr, data_in, data_out;
  logic        memWE;

  logic [1:0]  req_s   [2];
  logic [1:0]  ack_s   [2];
  logic        err_s   [2];
  logic [15:0] rdata_s [2];
  logic [15:0] maddr_s [2];
  logic [15:0] din_s   [2];
  logic        memwe_s [2];
  logic [15:0] probe_addr;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic two_hot_seen = 1'b0;

  always #5 clk = ~clk;

  lc3_mem_arb #(.NUM_CH(2), .DATA_W(16), .ADDR_W(16), .WAIT_STATES(1), .MEM_DEPTH(32'h4000)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ack(ack), .err(err), .rdata(rdata), .addr(addr), .memWE(memWE),
    .data_in(data_in), .data_out(data_out)
  );

  lc3_mem_arb #(.NUM_CH(2), .DATA_W(16), .ADDR_W(16), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(2'b00), .ch_addr({16'h0000, probe_addr}),
    .ch_wdata(32'h0), .ack(ack_s[0]), .err(err_s[0]), .rdata(rdata_s[0]), .addr(maddr_s[0]),
    .memWE(memwe_s[0]), .data_in(din_s[0]), .data_out(data_out)
  );

  lc3_mem_arb #(.NUM_CH(2), .DATA_W(16), .ADDR_W(16), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(2'b00), .ch_addr({16'h0000, probe_addr}),
    .ch_wdata(32'h0), .ack(ack_s[1]), .err(err_s[1]), .rdata(rdata_s[1]), .addr(maddr_s[1]),
    .memWE(memwe_s[1]), .data_in(din_s[1]), .data_out(data_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits up to 20 negedges for an ack on the main DUT, logging memWE activity.
  task automatic wait_ack(output int lat, output logic [1:0] ack_v, output logic err_v,
                          output logic [15:0] rd_v, output int we_cyc,
                          output logic [15:0] we_a, output logic [15:0] we_d);
    lat = -1; ack_v = '0; err_v = 1'b0; rd_v = '0; we_cyc = 0; we_a = '0; we_d = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (memWE) begin
        we_cyc++;
        we_a = addr;
        we_d = data_in;
      end
      if ($countones(ack) > 1) two_hot_seen = 1'b1;
      if (ack != 2'b00) begin
        lat = k; ack_v = ack; err_v = err; rd_v = rdata;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int          lat, we_cyc;
    logic [1:0]  ack_v, exp_ack;
    logic        err_v;
    logic [15:0] rd_v, we_a, we_d;
    exp_ack = (v.ch == 0) ? 2'b01 : 2'b10;
    req[v.ch]               = 1'b1;
    we[v.ch]                = v.wr;
    ch_addr[v.ch*16 +: 16]  = v.a;
    ch_wdata[v.ch*16 +: 16] = v.wd;
    data_out                = v.mem;
    wait_ack(lat, ack_v, err_v, rd_v, we_cyc, we_a, we_d);
    checkOutput($sformatf("v%0d latency", idx), lat, v.exp_lat);
    checkOutput($sformatf("v%0d ack", idx), 32'(ack_v), 32'(exp_ack));
    checkOutput($sformatf("v%0d err", idx), 32'(err_v), 32'(v.exp_err));
    checkOutput($sformatf("v%0d memWE cycles", idx), we_cyc, v.exp_we_cyc);
    if (v.exp_we_cyc != 0) begin
      checkOutput($sformatf("v%0d write addr", idx), 32'(we_a), 32'(v.a));
      checkOutput($sformatf("v%0d write data", idx), 32'(we_d), 32'(v.wd));
    end
    if (!v.wr || v.exp_err)
      checkOutput($sformatf("v%0d rdata", idx), 32'(rd_v), 32'(v.exp_rdata));
    @(posedge clk);
    #1;
    req = 2'b00;
    we  = 2'b00;
    @(negedge clk);
    checkOutput($sformatf("v%0d ack single pulse", idx), 32'(ack), 32'h0);
  endtask

  task automatic probe(input int d, input int exp_lat);
    int   lat;
    logic bad_we, bad_addr;
    logic [1:0]  ack_v;
    logic [15:0] rd_v;
    logic        err_v;
    lat = -1; bad_we = 1'b0; bad_addr = 1'b0; ack_v = '0; rd_v = '0; err_v = 1'b0;
    req_s[d] = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (memwe_s[d]) bad_we = 1'b1;
      if (maddr_s[d] != probe_addr || din_s[d] != 16'h0) bad_addr = 1'b1;
      if (ack_s[d] != 2'b00) begin
        lat = k; ack_v = ack_s[d]; rd_v = rdata_s[d]; err_v = err_s[d];
        break;
      end
    end
    checkOutput($sformatf("ws probe %0d latency", d), lat, exp_lat);
    checkOutput($sformatf("ws probe %0d ack", d), 32'(ack_v), 32'h1);
    checkOutput($sformatf("ws probe %0d rdata", d), 32'(rd_v), 32'hC0DE);
    checkOutput($sformatf("ws probe %0d err", d), 32'(err_v), 32'h0);
    checkOutput($sformatf("ws probe %0d memWE/bus", d), {30'h0, bad_we, bad_addr}, 32'h0);
    @(posedge clk);
    #1;
    req_s[d] = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [6];
    int          lat, we_cyc, stray;
    logic [1:0]  ack_v, g;
    logic        err_v;
    logic [15:0] rd_v, we_a, we_d;

    vecs[0] = '{0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 3, 0};
    vecs[1] = '{1, 1'b1, 16'h0010, 16'h1234, 16'h0000, 16'h0000, 1'b0, 3, 1};
    vecs[2] = '{0, 1'b1, 16'h8000, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 3, 0};
    vecs[3] = '{1, 1'b0, 16'h3FFF, 16'h0000, 16'h1357, 16'h1357, 1'b0, 3, 0};
    vecs[4] = '{0, 1'b0, 16'h4000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 3, 0};
    vecs[5] = '{1, 1'b1, 16'h3FFF, 16'h0F0F, 16'h0000, 16'h0000, 1'b0, 3, 1};

    rst = 1'b1; req = '0; we = '0; ch_addr = '0; ch_wdata = '0; data_out = '0;
    req_s[0] = '0; req_s[1] = '0; probe_addr = 16'h0123;
    repeat (2) @(negedge clk);
    checkOutput("reset ack", 32'(ack), 32'h0);
    checkOutput("reset err/memWE", {30'h0, err, memWE}, 32'h0);
    checkOutput("reset rdata", 32'(rdata), 32'h0);
    checkOutput("reset addr", 32'(addr), 32'h0);
    checkOutput("reset data_in", 32'(data_in), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-transaction vectors");
    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    $display("[TB] round-robin with both channels requesting");
    ch_addr  = {16'h0200, 16'h0100};
    data_out = 16'h0042;
    req      = 2'b11;
    for (int r = 0; r < 4; r++) begin
      wait_ack(lat, ack_v, err_v, rd_v, we_cyc, we_a, we_d);
      checkOutput($sformatf("rr round %0d grant", r), 32'(ack_v), (r % 2 == 0) ? 32'h1 : 32'h2);
      g = ack_v;
      @(posedge clk);
      #1;
      if (r == 3) begin
        req = 2'b00;
      end else begin
        req = req & ~g;
        @(posedge clk);
        #1;
        req = req | g;
      end
    end
    @(negedge clk);
    checkOutput("rr ack never two-hot", 32'(two_hot_seen), 32'h0);

    $display("[TB] reset during write access");
    req = 2'b01; we = 2'b01; ch_addr[15:0] = 16'h0100; ch_wdata[15:0] = 16'h5A5A;
    repeat (2) @(negedge clk);
    checkOutput("abort memWE before reset", 32'(memWE), 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort memWE drops", 32'(memWE), 32'h0);
    checkOutput("abort ack", 32'(ack), 32'h0);
    checkOutput("abort rdata cleared", 32'(rdata), 32'h0);
    checkOutput("abort addr cleared", 32'(addr), 32'h0);
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != 2'b00 || memWE) stray++;
    end
    checkOutput("abort no late ack", stray, 0);
    req = 2'b11;
    wait_ack(lat, ack_v, err_v, rd_v, we_cyc, we_a, we_d);
    checkOutput("post-reset grant ch0", 32'(ack_v), 32'h1);
    @(posedge clk);
    #1 req = 2'b10;
    wait_ack(lat, ack_v, err_v, rd_v, we_cyc, we_a, we_d);
    checkOutput("post-reset then ch1", 32'(ack_v), 32'h2);
    @(posedge clk);
    #1 req = 2'b00;
    @(negedge clk);

    $display("[TB] wait-state latency sweep");
    data_out = 16'hC0DE;
    probe(0, 2);
    probe(1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
